// File: rtl/sr04_sensor_emu.sv
// sr04_sensor_emu
//   Emulates the responder side of an HC-SR04 ultrasonic sensor so the sr04
//   controller can be looped back on-chip. A trigger pulse is synchronized and
//   qualified by width. After a fixed burst delay the block drives an echo pulse
//   whose width encodes the programmed distance (58 us per cm). It then holds
//   off for a recovery period before it accepts another trigger.
//
// Build option:
//   SR04_EMU_TIMEOUT_EN - when defined, an out-of-range distance (0 or above
//                         MAX_CM) produces a 38000 us "no object" echo. When
//                         undefined, an out-of-range distance gives no echo.
//
// Ports:
//   clk               system clock
//   reset             asynchronous active-high reset
//   en                enable; low returns the block to IDLE on the next clock
//   sensor_trigger_in trigger from the controller (asynchronous, 2-FF synced)
//   distance_cm       emulated distance, captured when a trigger is qualified
//   sensor_echo_out   echo pulse (registered)
//   busy              high whenever the FSM is not in IDLE (registered)
//   runt              one-clock pulse when a too-short trigger is rejected
//   dbg_state_o       current FSM state, for checkers (IDLE reads as 0)
module sr04_sensor_emu #(
  parameter int frequency   = 16000000,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int HOLDOFF_US  = 1000,
  parameter int MAX_CM      = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sensor_trigger_in,
  input  logic [8:0] distance_cm,
  output logic       sensor_echo_out,
  output logic       busy,
  output logic       runt,
  output logic [2:0] dbg_state_o
);

  localparam int CLKS_PER_US   = (frequency / 1000000 > 1) ? frequency / 1000000 : 1;
  // The longest interval ever loaded is the 38000 us timeout echo; the counter
  // is never narrower than 16 bits.
  localparam int ECHO_MAX_CLKS = 38000 * CLKS_PER_US;
  localparam int CNT_W         = ($clog2(ECHO_MAX_CLKS + 1) > 16) ? $clog2(ECHO_MAX_CLKS + 1) : 16;

  localparam logic [CNT_W-1:0] ONE           = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_MIN_CLKS = CNT_W'(TRIG_MIN_US * CLKS_PER_US);
  // Down-counters are loaded with (length - 1) so a state lasts exactly
  // `length` clocks, leaving on the clock after the counter reads zero.
  localparam logic [CNT_W-1:0] BURST_LOAD    = CNT_W'(BURST_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD     = CNT_W'(HOLDOFF_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] ECHO_PER_CM   = CNT_W'(58 * CLKS_PER_US);
`ifdef SR04_EMU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD  = CNT_W'(ECHO_MAX_CLKS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       dist_q, dist_d;
  logic [1:0]       sync_q;
  logic             echo_q, busy_q, runt_q, runt_d;
  logic             trig_s;
  logic             in_range;
  logic [CNT_W-1:0] echo_load;

  assign trig_s    = sync_q[1];
  assign in_range  = (dist_q != 9'd0) && (int'(dist_q) <= MAX_CM);
  assign echo_load = CNT_W'(dist_q) * ECHO_PER_CM - ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    runt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_s) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        // cnt_q is an up-counting width measurement here, saturating at all-ones.
        if (trig_s) begin
          if (cnt_q != '1) cnt_d = cnt_q + ONE;
        end else if (cnt_q >= TRIG_MIN_CLKS) begin
          dist_d  = distance_cm;
          state_d = BURST;
          cnt_d   = BURST_LOAD;
        end else begin
          runt_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (in_range) begin
          state_d = ECHO;
          cnt_d   = echo_load;
        end else begin
`ifdef SR04_EMU_TIMEOUT_EN
          state_d = ECHO;
          cnt_d   = TIMEOUT_LOAD;
`else
          state_d = HOLDOFF;
          cnt_d   = HOLD_LOAD;
`endif
        end
      end
      ECHO: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLDOFF: begin
        // After the recovery time the counter parks at zero until the
        // trigger is released, so a held trigger cannot re-fire.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (!trig_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      dist_d  = '0;
      runt_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
      sync_q  <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      runt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      sync_q  <= {sync_q[0], sensor_trigger_in};
      // Outputs are registered from the next state so they line up with it.
      echo_q  <= (state_d == ECHO);
      busy_q  <= (state_d != IDLE);
      runt_q  <= runt_d;
    end
  end

  assign sensor_echo_out = echo_q;
  assign busy            = busy_q;
  assign runt            = runt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sr04_sensor_emu.sv
// tb_sr04_sensor_emu
//   Drives trigger pulses into sr04_sensor_emu at 2 MHz (2 clocks per us) and
//   compares echo timing, busy and runt behaviour against a transaction-level
//   model of the sensor: echo = distance*58 us after a 200 us burst, then a
//   1000 us holdoff.
module tb_sr04_sensor_emu;

  localparam int FREQ       = 2000000;
  localparam int CPU        = 2;
  localparam int TRIG_MIN   = 10;
  localparam int BURST_US   = 200;
  localparam int HOLD_US    = 1000;
  localparam int MAX_CM     = 400;
  localparam int BURST_CLKS = BURST_US * CPU;
  localparam int HOLD_CLKS  = HOLD_US * CPU;
  localparam int TMIN_CLKS  = TRIG_MIN * CPU;
`ifdef SR04_EMU_TIMEOUT_EN
  localparam int N_RAND = 0;
`else
  localparam int N_RAND = 6;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       trig;
  logic [8:0] distance;
  logic       sensor_echo_out;
  logic       busy;
  logic       runt;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr04_sensor_emu #(
    .frequency  (FREQ),
    .TRIG_MIN_US(TRIG_MIN),
    .BURST_US   (BURST_US),
    .HOLDOFF_US (HOLD_US),
    .MAX_CM     (MAX_CM)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .sensor_trigger_in(trig),
    .distance_cm      (distance),
    .sensor_echo_out  (sensor_echo_out),
    .busy             (busy),
    .runt             (runt),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: echo length in clocks for a qualified trigger.
  function automatic int model_echo_clks(input int d);
    if (d >= 1 && d <= MAX_CM) return d * 58 * CPU;
`ifdef SR04_EMU_TIMEOUT_EN
    return 38000 * CPU;
`else
    return 0;
`endif
  endfunction

  // ---------------- monitor (samples on falling edge) ----------------
  int n_rise = 0, n_fall = 0, n_brise = 0, n_bfall = 0, n_runt = 0, runt_hi = 0;
  int rise_cyc = 0, fall_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0, runt_cyc = 0;
  logic echo_p = 1'b0, busy_p = 1'b0, runt_p = 1'b0;

  always @(negedge clk) begin
    if (sensor_echo_out && !echo_p) begin n_rise++;  rise_cyc = cyc;      end
    if (!sensor_echo_out && echo_p) begin n_fall++;  fall_cyc = cyc;      end
    if (busy && !busy_p)            begin n_brise++; busy_rise_cyc = cyc; end
    if (!busy && busy_p)            begin n_bfall++; busy_fall_cyc = cyc; end
    if (runt && !runt_p)            begin n_runt++;  runt_cyc = cyc;      end
    if (runt) runt_hi++;
    echo_p = sensor_echo_out;
    busy_p = busy;
    runt_p = runt;
  end

  function automatic int evt_count(input int which);
    case (which)
      0:       return n_rise;
      1:       return n_fall;
      default: return n_bfall;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_evt(input int which, input int n0, input int budget, input string tag);
    int k = 0;
    while (evt_count(which) <= n0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, int'(evt_count(which) > n0), 1);
  endtask

  task automatic trig_pulse(input int w, output int t_rise, output int t_fall);
    @(posedge clk);
    #1 trig = 1'b1;
    t_rise = cyc;
    repeat (w) @(posedge clk);
    #1 trig = 1'b0;
    t_fall = cyc;
  endtask

  task automatic txn(input int w, input int d, input int d_late, input string tag);
    int tr, tf, e, nr0, nf0, nb0, nrunt0, nhi0;
    e      = model_echo_clks(d);
    nr0    = n_rise;
    nf0    = n_fall;
    nb0    = n_bfall;
    nrunt0 = n_runt;
    nhi0   = runt_hi;
    distance = 9'(d);
    trig_pulse(w, tr, tf);
    chk({tag, "_busy_rise"}, busy_rise_cyc - tr, 3);
    if (w < TMIN_CLKS) begin
      repeat (6) tick();
      chk({tag, "_runt_count"}, n_runt - nrunt0, 1);
      chk({tag, "_runt_delay"}, runt_cyc - tf, 3);
      chk({tag, "_runt_width"}, runt_hi - nhi0, 1);
      chk({tag, "_runt_idle"}, int'(busy), 0);
      chk({tag, "_runt_no_echo"}, n_rise - nr0, 0);
    end else begin
      if (d_late >= 0) begin
        repeat (50) @(posedge clk);
        #1 distance = 9'(d_late);
      end
      if (e > 0) begin
        exp_q.push_back(32'(e));
        wait_evt(1, nf0, 3 + BURST_CLKS + e + 60, {tag, "_echo_seen"});
        chk({tag, "_echo_delay"}, rise_cyc - tf, 3 + BURST_CLKS);
        chk({tag, "_echo_width"}, fall_cyc - rise_cyc, int'(exp_q.pop_front()));
        wait_evt(2, nb0, HOLD_CLKS + 60, {tag, "_busy_fall_seen"});
        chk({tag, "_holdoff"}, busy_fall_cyc - fall_cyc, HOLD_CLKS);
      end else begin
        wait_evt(2, nb0, 3 + BURST_CLKS + HOLD_CLKS + 60, {tag, "_busy_fall_seen"});
        chk({tag, "_busy_span"}, busy_fall_cyc - tf, 3 + BURST_CLKS + HOLD_CLKS);
        chk({tag, "_no_echo"}, n_rise - nr0, 0);
      end
      chk({tag, "_no_runt"}, n_runt - nrunt0, 0);
    end
    repeat (3) tick();
  endtask

  // Second trigger during ECHO must neither stretch the echo nor produce runt.
  task automatic test_reject();
    int nr0, nrunt0, tr2, tf2;
    nr0    = n_rise;
    nrunt0 = n_runt;
    fork
      txn(24, 10, -1, "reject");
      begin
        wait_evt(0, nr0, 3 + BURST_CLKS + 60, "reject_echo_up");
        repeat (100) @(posedge clk);
        trig_pulse(24, tr2, tf2);
        chk("reject_pulse_in_echo", int'(tr2 > rise_cyc && tf2 - rise_cyc < 1160), 1);
      end
    join
    chk("reject_no_runt", n_runt - nrunt0, 0);
  endtask

  // Trigger held across the end of HOLDOFF: no re-fire until released.
  task automatic test_hold();
    int tr, tf, nr0, nf0, nb0, t_rel;
    nr0 = n_rise;
    nf0 = n_fall;
    distance = 9'd1;
    trig_pulse(24, tr, tf);
    wait_evt(1, nf0, 3 + BURST_CLKS + 116 + 60, "hold_echo_seen");
    chk("hold_echo_width", fall_cyc - rise_cyc, 116);
    repeat (1000) @(posedge clk);
    #1 trig = 1'b1;
    repeat (HOLD_CLKS - 1000 + 100) tick();
    nb0 = n_bfall;
    chk("hold_still_busy", int'(busy), 1);
    chk("hold_no_new_echo", n_rise - nr0, 1);
    @(posedge clk);
    #1 trig = 1'b0;
    t_rel = cyc;
    wait_evt(2, nb0, 20, "hold_release_seen");
    chk("hold_release_delay", busy_fall_cyc - t_rel, 3);
    repeat (50) tick();
    chk("hold_no_retrigger", n_rise - nr0, 1);
    chk("hold_tr", tf - tr, 24);
  endtask

  task automatic test_abort_en();
    int tr, tf, nr0;
    nr0 = n_rise;
    distance = 9'd10;
    trig_pulse(24, tr, tf);
    wait_evt(0, nr0, 3 + BURST_CLKS + 60, "abort_en_echo_up");
    chk("abort_en_rise_delay", rise_cyc - tf, 3 + BURST_CLKS);
    repeat (200) @(posedge clk);
    #1;
    chk("abort_en_pre_echo", int'(sensor_echo_out), 1);
    en = 1'b0;
    @(posedge clk);
    tick();
    chk("abort_en_echo", int'(sensor_echo_out), 0);
    chk("abort_en_busy", int'(busy), 0);
    en = 1'b1;
    repeat (5) tick();
    chk("abort_en_stays_idle", int'(busy), 0);
  endtask

  task automatic test_abort_reset();
    int tr, tf, nr0;
    nr0 = n_rise;
    distance = 9'd10;
    trig_pulse(24, tr, tf);
    wait_evt(0, nr0, 3 + BURST_CLKS + 60, "abort_rst_echo_up");
    repeat (100) tick();
    chk("abort_rst_pre_echo", int'(sensor_echo_out), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_rst_echo", int'(sensor_echo_out), 0);
    chk("abort_rst_busy", int'(busy), 0);
    chk("abort_rst_runt", int'(runt), 0);
    chk("abort_rst_state", int'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) tick();
    chk("abort_rst_idle", int'(busy), 0);
    chk("abort_rst_width", tf - tr, 24);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w, d;
    reset    = 1'b1;
    en       = 1'b1;
    trig     = 1'b0;
    distance = 9'd0;
    repeat (3) @(posedge clk);
    tick();
    chk("rst_echo", int'(sensor_echo_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_runt", int'(runt), 0);
    chk("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick();

    txn(24, 10, -1, "nominal");
    txn(16, 10, -1, "runt");
    txn(19, 10, -1, "runt_long");
    txn(24, 450, -1, "out_of_range");
    test_reject();
    test_hold();
    txn(24, 1, -1, "reassert");
    txn(24, 10, 100, "latch");
    test_abort_en();
    test_abort_reset();

    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 3) == 0) w = $urandom_range(4, 18);
      else                           w = $urandom_range(22, 40);
      if ($urandom_range(0, 4) == 0) d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(401, 511);
      else                           d = $urandom_range(1, 20);
      txn(w, d, -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
